// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: response-owner encoding and default starvation limit.
// No logic; types and constants only.
// No flow control of its own.
package mem_arb_pkg;

   // Which channel owns the read data returning from memory next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   // Consecutive denied fetch cycles tolerated before fetch is forced through.
   localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the memory port arbiter.
// Purely wiring; the arbiter side drives grants, responses and the memory command.
// Requesters hold req/address until gnt; no valid/ready beyond that.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch channel
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_flush;
   // data channel
   logic              dm_req;
   logic [3:0]        dm_wen;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   // memory side
   logic              mem_en;
   logic [3:0]        mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // arbiter view
   modport slave (
      input  if_req, if_addr, if_flush,
      input  dm_req, dm_wen, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_wen, mem_addr, mem_wdata
   );

   // requester + memory view
   modport master (
      output if_req, if_addr, if_flush,
      output dm_req, dm_wen, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive cycles the fetch channel is requesting but denied; flags starvation at the limit.
// starve is a registered-count compare, valid in the same cycle it is used.
// Flush cycles hold the count; any fetch grant or dropped request clears it.
module mem_arb_starve_cnt
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic if_req,
   input  logic if_gnt,
   input  logic if_flush,
   output logic starve
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on grant or idle, hold on flush, saturate at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (!if_req || if_gnt) begin
         cnt_d = '0;
      end else if (!if_flush && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (IF) and data (DM) requesters onto one single-port synchronous memory.
// Grant is combinational in the request cycle; read data returns one cycle later.
// Losing requester is simply not granted and must hold its request; optional MEM_ARB_STARVE_EN forces fetch after repeated denials.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   mem_port_arbiter_if.slave   bus
);

   logic              if_req_v;
   logic              dm_req_v;
   logic              force_if;
   logic              if_gnt;
   logic              dm_gnt;
   logic              mem_en;
   logic [3:0]        mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   owner_e            owner_q;
   owner_e            owner_d;
   logic              if_rvalid;
   logic              dm_rvalid;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [DATA_W-1:0] dm_rdata_d;

`ifdef MEM_ARB_STARVE_EN
   logic starve;

   mem_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .if_req   (if_req_v),
      .if_gnt   (if_gnt),
      .if_flush (bus.if_flush),
      .starve   (starve)
   );

   assign force_if = starve;
`else
   // Fixed priority build: the limit parameter has no effect but stays referenced.
   logic unused_starve_cfg;
   assign unused_starve_cfg = (STARVE_LIMIT == 0);
   assign force_if = 1'b0;
`endif

   // Arbitration and memory command: dm wins unless fetch is being forced; reset masks everything.
   always_comb begin
      if_req_v  = bus.if_req & resetn;
      dm_req_v  = bus.dm_req & resetn;
      if_gnt    = if_req_v & ~bus.if_flush & (~dm_req_v | force_if);
      dm_gnt    = dm_req_v & ~if_gnt;
      mem_en    = if_gnt | dm_gnt;
      mem_wen   = 4'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dm_gnt) begin
         mem_wen   = bus.dm_wen;
         mem_addr  = bus.dm_addr;
         mem_wdata = bus.dm_wdata;
      end else if (if_gnt) begin
         mem_addr  = bus.if_addr;
      end
   end

   // Response owner for next cycle's read data; writes produce no response.
   always_comb begin
      owner_d = OWN_NONE;
      if (if_gnt) begin
         owner_d = OWN_IF;
      end else if (dm_gnt && (bus.dm_wen == 4'b0)) begin
         owner_d = OWN_DM;
      end
   end

   // Response steering; a flush kills the fetch response arriving this cycle, rdata holds otherwise.
   always_comb begin
      if_rvalid  = (owner_q == OWN_IF) & ~bus.if_flush;
      dm_rvalid  = (owner_q == OWN_DM);
      if_rdata_d = if_rvalid ? bus.mem_rdata : if_rdata_q;
      dm_rdata_d = dm_rvalid ? bus.mem_rdata : dm_rdata_q;
   end

   // Owner and last-delivered data registers; reset drops any in-flight response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q    <= OWN_NONE;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         owner_q    <= owner_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.dm_gnt    = dm_gnt;
   assign bus.if_rvalid = if_rvalid;
   assign bus.dm_rvalid = dm_rvalid;
   assign bus.if_rdata  = if_rdata_d;
   assign bus.dm_rdata  = dm_rdata_d;
   assign bus.mem_en    = mem_en;
   assign bus.mem_wen   = mem_wen;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors drive both channels against a behavioural synchronous memory.
// Grants are checked in the request cycle; read responses go through an expected-response queue.
// A monitor pops the queue whenever either rvalid is seen.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // behavioural single-port synchronous memory, 1-cycle read latency
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_wen[b]) mem[bus.mem_addr[7:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
         end
         bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      end
   end

   typedef struct {
      bit          is_if;
      logic [31:0] dat;
   } resp_t;

   resp_t sb[$];
   resp_t mon_r;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every rvalid must match the oldest expected response.
   always @(negedge clk) begin
      if (bus.if_rvalid === 1'b1 || bus.dm_rvalid === 1'b1) begin
         if (bus.if_rvalid === 1'b1 && bus.dm_rvalid === 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dual_rvalid: both rvalids high at %0t", $time);
         end else if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rvalid: if_rvalid=%0b dm_rvalid=%0b, none expected at %0t",
                     bus.if_rvalid, bus.dm_rvalid, $time);
         end else begin
            mon_r = sb.pop_front();
            chk("resp_channel_is_if", {31'b0, bus.if_rvalid}, {31'b0, mon_r.is_if});
            chk("resp_data", bus.if_rvalid ? bus.if_rdata : bus.dm_rdata, mon_r.dat);
         end
      end
   end

   // One request cycle: drive after the edge, check grants mid-cycle, queue the expected response.
   // resp: 0 none, 1 fetch response, 2 data response
   task automatic step(input logic ireq, input logic [31:0] iaddr, input logic fl,
                       input logic dreq, input logic [3:0] dwen, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic eig, input logic edg,
                       input int resp, input logic [31:0] rdat, input string tag);
      resp_t r;
      @(posedge clk);
      #1;
      bus.if_req   = ireq;
      bus.if_addr  = iaddr;
      bus.if_flush = fl;
      bus.dm_req   = dreq;
      bus.dm_wen   = dwen;
      bus.dm_addr  = daddr;
      bus.dm_wdata = dwdata;
      @(negedge clk);
      chk({tag, "_if_gnt"}, {31'b0, bus.if_gnt}, {31'b0, eig});
      chk({tag, "_dm_gnt"}, {31'b0, bus.dm_gnt}, {31'b0, edg});
      chk({tag, "_mem_en"}, {31'b0, bus.mem_en}, {31'b0, eig | edg});
      if (eig | edg) chk({tag, "_mem_addr"}, bus.mem_addr, edg ? daddr : iaddr);
      if (resp != 0) begin
         r.is_if = (resp == 1);
         r.dat   = rdat;
         sb.push_back(r);
      end
   endtask

   task automatic idle(input string tag);
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, tag);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_gnt"},    {31'b0, bus.if_gnt},    32'h0);
      chk({tag, "_dm_gnt"},    {31'b0, bus.dm_gnt},    32'h0);
      chk({tag, "_if_rvalid"}, {31'b0, bus.if_rvalid}, 32'h0);
      chk({tag, "_dm_rvalid"}, {31'b0, bus.dm_rvalid}, 32'h0);
      chk({tag, "_mem_en"},    {31'b0, bus.mem_en},    32'h0);
      chk({tag, "_mem_wen"},   {28'b0, bus.mem_wen},   32'h0);
      chk({tag, "_mem_addr"},  bus.mem_addr,           32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata,          32'h0);
      chk({tag, "_if_rdata"},  bus.if_rdata,           32'h0);
      chk({tag, "_dm_rdata"},  bus.dm_rdata,           32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[32'h20 >> 2] = 32'h24010001;
      mem[32'h24 >> 2] = 32'h33334444;
      mem[32'h14 >> 2] = 32'h11112222;
      bus.mem_rdata = 32'h0;
      // requests asserted during reset must be ignored
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h20;
      bus.if_flush = 1'b0;
      bus.dm_req   = 1'b1;
      bus.dm_wen   = 4'hF;
      bus.dm_addr  = 32'h14;
      bus.dm_wdata = 32'hFFFFFFFF;
      resetn       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      bus.dm_wen = 4'h0;
      resetn     = 1'b1;

      // fetch only
      step(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'h24010001, "fetch");
      chk("fetch_mem_wen", {28'b0, bus.mem_wen}, 32'h0);
      idle("fetch_resp");

      // collision: dm read wins, fetch next cycle, responses back to back
      step(1, 32'h24, 0, 1, 4'h0, 32'h14, 32'h0, 0, 1, 2, 32'h11112222, "coll_dm");
      step(1, 32'h24, 0, 0, 4'h0, 32'h0,  32'h0, 1, 0, 1, 32'h33334444, "coll_if");
      idle("coll_resp");

      // write, then read it back, then check both rdata hold
      step(0, 32'h0, 0, 1, 4'hF, 32'h1C, 32'hDEADBEEF, 0, 1, 0, 32'h0, "wr");
      chk("wr_mem_wen",   {28'b0, bus.mem_wen}, 32'hF);
      chk("wr_mem_wdata", bus.mem_wdata,        32'hDEADBEEF);
      step(0, 32'h0, 0, 1, 4'h0, 32'h1C, 32'h0, 0, 1, 2, 32'hDEADBEEF, "wr_rd");
      chk("wr_rd_mem_wen", {28'b0, bus.mem_wen}, 32'h0);
      idle("wr_rd_resp");
      idle("hold");
      chk("hold_dm_rvalid", {31'b0, bus.dm_rvalid}, 32'h0);
      chk("hold_dm_rdata",  bus.dm_rdata,           32'hDEADBEEF);
      chk("hold_if_rdata",  bus.if_rdata,           32'h33334444);

      // flush: fetch granted, next cycle flush kills its response and blocks fetch; dm still served
      step(1, 32'h20, 0, 0, 4'h0, 32'h0,  32'h0, 1, 0, 0, 32'h0,         "fl_fetch");
      step(1, 32'h24, 1, 1, 4'h0, 32'h14, 32'h0, 0, 1, 2, 32'h11112222, "fl_cyc");
      chk("fl_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
      idle("fl_resp");
      idle("fl_gap");

      // starvation: dm and fetch both held
      for (int k = 1; k <= 6; k++) begin
`ifdef MEM_ARB_STARVE_EN
         if (k == 5)
            step(1, 32'h20, 0, 1, 4'h0, 32'h14, 32'h0, 1, 0, 1, 32'h24010001, $sformatf("starve%0d", k));
         else
            step(1, 32'h20, 0, 1, 4'h0, 32'h14, 32'h0, 0, 1, 2, 32'h11112222, $sformatf("starve%0d", k));
`else
         step(1, 32'h20, 0, 1, 4'h0, 32'h14, 32'h0, 0, 1, 2, 32'h11112222, $sformatf("starve%0d", k));
`endif
      end
      idle("starve_resp");
      idle("starve_gap");

      // reset in the cycle after a dm read grant: response discarded, outputs zero
      step(0, 32'h0, 0, 1, 4'h0, 32'h14, 32'h0, 0, 1, 0, 32'h0, "rst_rd");
      @(posedge clk);
      #1;
      resetn      = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h20;
      @(negedge clk);
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      resetn     = 1'b1;
      @(negedge clk);
      chk("rst_rel_dm_rvalid", {31'b0, bus.dm_rvalid}, 32'h0);
      chk("rst_rel_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
      chk("rst_rel_dm_rdata",  bus.dm_rdata,           32'h0);
      idle("rst_gap");
      step(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 32'h24010001, "post_rst");
      idle("post_rst_resp");
      idle("drain");

      chk("pending_responses", sb.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch denials before forced fetch grant.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W: fetch channel from IF1.
REQ-007 SHALL have port if_flush  in  1  branch/jump flush from the pipeline.
REQ-008 SHALL have ports dm_req in 1, dm_wen in 4, dm_addr in ADDR_W, dm_wdata in DATA_W, dm_gnt out 1, dm_rvalid out 1, dm_rdata out DATA_W: data channel from MEM.
REQ-009 SHALL have ports mem_en out 1, mem_wen out 4, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port synchronous memory with 1-cycle read latency.

Function
REQ-010 SHALL grant at most one requester per cycle; grants are combinational in the request cycle; each requester holds req and address stable until gnt.
REQ-011 SHALL give dm priority over if when both request, except as REQ-022.
REQ-012 SHALL drive mem_en=1 and mem_addr/mem_wen/mem_wdata from the granted channel in the grant cycle; mem_wen=0 for fetch; mem_en=0 with no grant.
REQ-013 SHALL treat a dm grant with dm_wen!=0 as a write: no dm_rvalid issued.
REQ-014 SHALL record the owner of each read grant in a response-owner register (NONE/IF/DM), updated every cycle.
REQ-015 SHALL assert if_rvalid or dm_rvalid for exactly one cycle, the cycle after the read grant, with rdata = mem_rdata.
REQ-016 SHALL sustain one grant per cycle back-to-back, alternating owners allowed without bubbles.
REQ-017 SHALL, when if_flush=1, force if_gnt=0 that cycle and suppress the if_rvalid of a fetch granted in the previous cycle; dm traffic unaffected.
REQ-018 SHALL hold if_rdata/dm_rdata at last delivered value when rvalid=0.
REQ-019 SHALL ignore requests whose owner-channel lost arbitration; no queuing inside the block.

Reset
REQ-020 SHALL, while resetn=0, drive all outputs 0, response owner NONE, starvation counter 0.
REQ-021 SHALL discard any in-flight response when reset asserts mid-transaction; no rvalid after reset release until a new grant.

Configuration
REQ-022 SHALL, with MEM_ARB_STARVE_EN defined, count consecutive cycles with if_req=1 and if_gnt=0 (flush cycles excluded, counter held); at count==STARVE_LIMIT grant fetch over dm for one cycle, then clear counter.
REQ-023 SHALL, without MEM_ARB_STARVE_EN, use fixed dm-over-if priority and contain no counter logic.
REQ-024 SHALL clear the starvation counter on any if grant or when if_req=0.

Structure
REQ-025 SHALL place owner encoding (OWN_NONE=0, OWN_IF=1, OWN_DM=2) and default STARVE_LIMIT in shared package mem_arb_pkg.
REQ-026 SHALL implement the starvation counter as sub-module mem_arb_starve_cnt, instantiated only under MEM_ARB_STARVE_EN.

Verification
REQ-027 SHALL test fetch only: if_req, if_addr=0x20, mem_rdata=0x24010001 next cycle -> if_gnt same cycle, if_rvalid=1 with if_rdata=0x24010001 one cycle later.
REQ-028 SHALL test collision: if_req and dm_req (read, addr 0x14) together -> dm_gnt=1, if_gnt=0; fetch granted next cycle; dm_rvalid then if_rvalid in consecutive cycles.
REQ-029 SHALL test write: dm_wen=4'hF, addr 0x1C, wdata 0xDEADBEEF -> mem_wen=4'hF, mem_wdata=0xDEADBEEF, dm_rvalid stays 0.
REQ-030 SHALL test flush: fetch granted at cycle N, if_flush=1 at N+1 -> if_rvalid=0 at N+1, if_gnt=0 at N+1.
REQ-031 SHALL test starvation (macro on, STARVE_LIMIT=4): dm_req held high with if_req high -> if_gnt=1 on the 5th cycle, dm_gnt=0 that cycle; macro off -> if_gnt stays 0.
REQ-032 SHALL test reset mid-read: resetn=0 the cycle after a dm read grant -> dm_rvalid=0, all outputs 0 until new grant.
